// File: rtl/accel_vec_engine.sv
// Multi-lane vector ALU engine: streams words from memory in bursts, applies a
// per-lane add/sub/mul/pass with an immediate, and writes each burst back out.
module accel_vec_engine #(
    parameter int unsigned MEM_LEN_BITS  = 8,
    parameter int unsigned MEM_ADDR_BITS = 64,
    parameter int unsigned MEM_DATA_BITS = 64,
    parameter int unsigned LANE_BITS     = 8,
    parameter int unsigned MAX_BURST     = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     launch,
    output logic                     finish,
    input  logic [31:0]              length,
    input  logic [63:0]              inp_baddr,
    input  logic [63:0]              out_baddr,
    input  logic [1:0]               op,
    input  logic [LANE_BITS-1:0]     imm,
    output logic [31:0]              cycles,
    output logic                     mem_req_valid,
    output logic                     mem_req_opcode,
    output logic [MEM_LEN_BITS-1:0]  mem_req_len,
    output logic [MEM_ADDR_BITS-1:0] mem_req_addr,
    output logic                     mem_wr_valid,
    output logic [MEM_DATA_BITS-1:0] mem_wr_bits,
    input  logic                     mem_rd_valid,
    input  logic [MEM_DATA_BITS-1:0] mem_rd_bits,
    output logic                     mem_rd_ready
);

    localparam int unsigned LANES = MEM_DATA_BITS / LANE_BITS;
    localparam int unsigned IW    = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_DATA,
        WR_REQ,
        WR_DATA,
        DONE
    } state_t;

    state_t                   state;
    state_t                   state_next;
    logic [31:0]              rem;
    logic [MEM_ADDR_BITS-1:0] rd_addr;
    logic [MEM_ADDR_BITS-1:0] wr_addr;
    logic [IW-1:0]            idx;
    logic [1:0]               op_q;
    logic [LANE_BITS-1:0]     imm_q;
    logic [MEM_DATA_BITS-1:0] buffer [MAX_BURST];

    logic [31:0]              burst;
    logic [31:0]              burst_m1;
    logic                     last_beat;
    logic [MEM_ADDR_BITS-1:0] addr_step;
    logic                     rd_xfer;
    logic [MEM_DATA_BITS-1:0] alu_out;
    logic [LANE_BITS-1:0]     lane_v;
    logic [LANE_BITS-1:0]     res_v;

    assign burst     = (rem > 32'(MAX_BURST)) ? 32'(MAX_BURST) : rem;
    assign burst_m1  = burst - 32'd1;
    assign last_beat = (32'(idx) == burst_m1);
    assign addr_step = MEM_ADDR_BITS'(burst * 32'(MEM_DATA_BITS / 8));
    assign rd_xfer   = mem_rd_valid && mem_rd_ready;

    // Lanes are independent; all arithmetic wraps at LANE_BITS.
    always_comb begin
        alu_out = '0;
        lane_v  = '0;
        res_v   = '0;
        for (int unsigned l = 0; l < LANES; l++) begin
            lane_v = mem_rd_bits[l*LANE_BITS +: LANE_BITS];
            case (op_q)
                2'd0:    res_v = lane_v + imm_q;
                2'd1:    res_v = lane_v - imm_q;
                2'd2:    res_v = lane_v * imm_q;
                default: res_v = lane_v;
            endcase
            alu_out[l*LANE_BITS +: LANE_BITS] = res_v;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // Outputs are decoded from the state register so reset clears them at once.
    always_comb begin
        state_next     = state;
        finish         = 1'b0;
        mem_req_valid  = 1'b0;
        mem_req_opcode = 1'b0;
        mem_req_len    = '0;
        mem_req_addr   = '0;
        mem_wr_valid   = 1'b0;
        mem_wr_bits    = '0;
        mem_rd_ready   = 1'b0;
        case (state)
            IDLE: begin
                if (launch) state_next = (length == 32'd0) ? DONE : RD_REQ;
            end
            RD_REQ: begin
                mem_req_valid = 1'b1;
                mem_req_len   = MEM_LEN_BITS'(burst_m1);
                mem_req_addr  = rd_addr;
                state_next    = RD_DATA;
            end
            RD_DATA: begin
                mem_rd_ready = 1'b1;
                if (mem_rd_valid && last_beat) state_next = WR_REQ;
            end
            WR_REQ: begin
                mem_req_valid  = 1'b1;
                mem_req_opcode = 1'b1;
                mem_req_len    = MEM_LEN_BITS'(burst_m1);
                mem_req_addr   = wr_addr;
                state_next     = WR_DATA;
            end
            WR_DATA: begin
                mem_wr_valid = 1'b1;
                mem_wr_bits  = buffer[idx];
                if (last_beat) state_next = (rem != burst) ? RD_REQ : DONE;
            end
            DONE: begin
                finish     = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rem     <= '0;
            rd_addr <= '0;
            wr_addr <= '0;
            idx     <= '0;
            op_q    <= '0;
            imm_q   <= '0;
            cycles  <= '0;
        end else begin
            if (state != IDLE && cycles != '1) cycles <= cycles + 32'd1;
            case (state)
                IDLE: begin
                    if (launch) begin
                        rem     <= length;
                        rd_addr <= MEM_ADDR_BITS'(inp_baddr);
                        wr_addr <= MEM_ADDR_BITS'(out_baddr);
                        op_q    <= op;
                        imm_q   <= imm;
                        cycles  <= '0;
                        idx     <= '0;
                    end
                end
                RD_REQ, WR_REQ: idx <= '0;
                RD_DATA: begin
                    if (rd_xfer) idx <= last_beat ? '0 : idx + IW'(1);
                end
                WR_DATA: begin
                    if (last_beat) begin
                        idx     <= '0;
                        rem     <= rem - burst;
                        rd_addr <= rd_addr + addr_step;
                        wr_addr <= wr_addr + addr_step;
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Burst buffer holds data only; it needs no reset.
    always_ff @(posedge clock) begin
        if (rd_xfer) buffer[idx] <= alu_out;
    end

endmodule

// File: tb/tb_accel_vec_engine.sv
// Directed bench for accel_vec_engine: a small memory responder feeds read bursts
// and logs requests, write beats and finish pulses for comparison.
module tb_accel_vec_engine;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        launch = 1'b0;
    logic        finish;
    logic [31:0] length = '0;
    logic [63:0] inp_baddr = '0;
    logic [63:0] out_baddr = '0;
    logic [1:0]  op = '0;
    logic [7:0]  imm = '0;
    logic [31:0] cycles;
    logic        mem_req_valid;
    logic        mem_req_opcode;
    logic [7:0]  mem_req_len;
    logic [63:0] mem_req_addr;
    logic        mem_wr_valid;
    logic [63:0] mem_wr_bits;
    logic        mem_rd_valid = 1'b0;
    logic [63:0] mem_rd_bits = '0;
    logic        mem_rd_ready;

    always #5 clock = ~clock;

    accel_vec_engine #(
        .MEM_LEN_BITS (8),
        .MEM_ADDR_BITS(64),
        .MEM_DATA_BITS(64),
        .LANE_BITS    (8),
        .MAX_BURST    (16)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .launch        (launch),
        .finish        (finish),
        .length        (length),
        .inp_baddr     (inp_baddr),
        .out_baddr     (out_baddr),
        .op            (op),
        .imm           (imm),
        .cycles        (cycles),
        .mem_req_valid (mem_req_valid),
        .mem_req_opcode(mem_req_opcode),
        .mem_req_len   (mem_req_len),
        .mem_req_addr  (mem_req_addr),
        .mem_wr_valid  (mem_wr_valid),
        .mem_wr_bits   (mem_wr_bits),
        .mem_rd_valid  (mem_rd_valid),
        .mem_rd_bits   (mem_rd_bits),
        .mem_rd_ready  (mem_rd_ready)
    );

    typedef struct packed {
        logic        opc;
        logic [7:0]  len;
        logic [63:0] addr;
    } req_t;

    typedef struct {
        logic [31:0] length;
        logic [1:0]  op;
        logic [7:0]  imm;
        logic [63:0] seed;
        logic [63:0] inp;
        logic [63:0] outb;
        bit          gap;
        bit          relaunch;
        logic [63:0] exp_first;
        int unsigned exp_reqs;
        int unsigned exp_cycles;   // 0: not checked
    } vec_t;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    req_t        req_q[$];
    logic [63:0] wr_q[$];
    int unsigned fin_cnt = 0;

    bit          gap_mode = 1'b0;
    logic [63:0] seed = '0;
    logic [63:0] inp_base = '0;
    int unsigned pending = 0;
    int unsigned beat_in = 0;
    int unsigned gap_ctr = 0;
    logic [63:0] rd_req_addr = '0;
    bit          xfer_prev = 1'b0;

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step;
        @(negedge clock);
        #1;
    endtask

    function automatic logic [63:0] ref_alu(input logic [63:0] w, input logic [1:0] o, input logic [7:0] k);
        logic [63:0] r;
        logic [7:0]  a;
        logic [15:0] p;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            a = w[i*8 +: 8];
            p = a * k;
            case (o)
                2'd0:    r[i*8 +: 8] = a + k;
                2'd1:    r[i*8 +: 8] = a - k;
                2'd2:    r[i*8 +: 8] = p[7:0];
                default: r[i*8 +: 8] = a;
            endcase
        end
        return r;
    endfunction

    // Read responder: word at address A is seed + (A - inp_base)/8.
    always @(negedge clock) begin
        if (!reset) begin
            pending      = 0;
            xfer_prev    = 1'b0;
            mem_rd_valid = 1'b0;
        end else begin
            if (xfer_prev) begin
                beat_in++;
                pending--;
            end
            if (mem_req_valid && !mem_req_opcode) begin
                pending     = 32'(mem_req_len) + 1;
                rd_req_addr = mem_req_addr;
                beat_in     = 0;
            end
            gap_ctr++;
            mem_rd_valid = (pending > 0) && (!gap_mode || (gap_ctr % 3 == 0));
            mem_rd_bits  = seed + ((rd_req_addr - inp_base) >> 3) + 64'(beat_in);
            xfer_prev    = mem_rd_valid && mem_rd_ready;
        end
    end

    always @(negedge clock) begin
        if (reset) begin
            if (mem_req_valid) req_q.push_back({mem_req_opcode, mem_req_len, mem_req_addr});
            if (mem_wr_valid)  wr_q.push_back(mem_wr_bits);
            if (finish)        fin_cnt++;
        end
    end

    task automatic run_vec(input vec_t v, input string tag);
        int unsigned mism;
        int unsigned k;
        int unsigned remaining;
        int unsigned bl;
        int unsigned b;
        req_t        e;
        step;
        req_q.delete();
        wr_q.delete();
        fin_cnt   = 0;
        length    = v.length;
        op        = v.op;
        imm       = v.imm;
        inp_baddr = v.inp;
        out_baddr = v.outb;
        seed      = v.seed;
        inp_base  = v.inp;
        gap_mode  = v.gap;
        launch    = 1'b1;
        step;
        launch = 1'b0;
        check64({tag, "_first_req_latency"}, 64'({mem_req_valid, mem_req_opcode}), 64'b10);
        for (int c = 0; c < 3000 && fin_cnt == 0; c++) begin
            step;
            if (v.relaunch && c == 10) begin
                launch = 1'b1;
                length = 32'd5;
                op     = 2'd3;
            end else begin
                launch = 1'b0;
            end
        end
        launch = 1'b0;
        repeat (3) step;
        check64({tag, "_finish_count"}, 64'(fin_cnt), 64'd1);
        check64({tag, "_wr_beats"}, 64'(wr_q.size()), 64'(v.length));
        check64({tag, "_req_count"}, 64'(req_q.size()), 64'(v.exp_reqs));
        if (wr_q.size() > 0) check64({tag, "_first_beat"}, wr_q[0], v.exp_first);
        mism = 0;
        for (int i = 0; i < wr_q.size(); i++)
            if (wr_q[i] !== ref_alu(v.seed + 64'(i), v.op, v.imm)) mism++;
        check64({tag, "_beat_data_mismatches"}, 64'(mism), 64'd0);
        mism = 0;
        k = 0;
        b = 0;
        remaining = v.length;
        while (remaining > 0) begin
            bl = (remaining > 16) ? 16 : remaining;
            e = {1'b0, 8'(bl - 1), v.inp + 64'(b) * 64'd128};
            if (k >= req_q.size() || req_q[k] !== e) mism++;
            k++;
            e = {1'b1, 8'(bl - 1), v.outb + 64'(b) * 64'd128};
            if (k >= req_q.size() || req_q[k] !== e) mism++;
            k++;
            remaining -= bl;
            b++;
        end
        check64({tag, "_req_seq_mismatches"}, 64'(mism), 64'd0);
        if (v.exp_cycles != 0) check64({tag, "_cycles"}, 64'(cycles), 64'(v.exp_cycles));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs[6];
        vec_t        v6;
        logic        any_out;
        int unsigned fin_before;
        bit          hit;

        vecs[0] = '{32'd1,  2'd0, 8'h01, 64'h00FF0102030405FE, 64'h1000, 64'h8000, 1'b0, 1'b0,
                    64'h01000203040506FF, 2, 5};
        vecs[1] = '{32'd1,  2'd2, 8'h03, 64'h9090909090909090, 64'h1000, 64'h8000, 1'b0, 1'b0,
                    64'hB0B0B0B0B0B0B0B0, 2, 5};
        vecs[2] = '{32'd1,  2'd1, 8'h01, 64'h0000000000000000, 64'h1000, 64'h8000, 1'b0, 1'b0,
                    64'hFFFFFFFFFFFFFFFF, 2, 5};
        vecs[3] = '{32'd3,  2'd3, 8'h55, 64'h0123456789ABCDEF, 64'h1000, 64'h8000, 1'b0, 1'b0,
                    64'h0123456789ABCDEF, 2, 9};
        vecs[4] = '{32'd40, 2'd0, 8'h01, 64'h1111111111111111, 64'h1000, 64'h8000, 1'b0, 1'b0,
                    64'h1212121212121212, 6, 87};
        vecs[5] = '{32'd20, 2'd2, 8'h05, 64'h0102030405060708, 64'h2000, 64'hFFFFFFFFFFFFFFC0, 1'b1, 1'b1,
                    64'h050A0F14191E2328, 4, 0};
        v6      = '{32'd2,  2'd0, 8'h01, 64'hA0A0A0A0A0A0A0A0, 64'h3000, 64'h9000, 1'b0, 1'b0,
                    64'hA1A1A1A1A1A1A1A1, 2, 7};

        repeat (2) step;
        any_out = finish | mem_req_valid | mem_req_opcode | (|mem_req_len) | (|mem_req_addr)
                | mem_wr_valid | (|mem_wr_bits) | mem_rd_ready | (|cycles);
        check64("reset_outputs_zero", 64'(any_out), 64'd0);
        reset = 1'b1;
        step;

        for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Zero-length launch goes straight to DONE.
        step;
        req_q.delete();
        fin_cnt = 0;
        length  = 32'd0;
        launch  = 1'b1;
        step;
        launch = 1'b0;
        check64("len0_finish_high", 64'(finish), 64'd1);
        check64("len0_no_req", 64'(mem_req_valid), 64'd0);
        step;
        check64("len0_finish_low", 64'(finish), 64'd0);
        step;
        check64("len0_cycles", 64'(cycles), 64'd1);
        check64("len0_finish_count", 64'(fin_cnt), 64'd1);
        check64("len0_req_count", 64'(req_q.size()), 64'd0);

        // Reset during RD_DATA of a long run, then relaunch.
        step;
        fin_cnt   = 0;
        length    = 32'd40;
        op        = 2'd0;
        imm       = 8'h01;
        inp_baddr = 64'h1000;
        out_baddr = 64'h8000;
        seed      = 64'h0;
        inp_base  = 64'h1000;
        gap_mode  = 1'b0;
        launch    = 1'b1;
        step;
        launch = 1'b0;
        hit = 1'b0;
        for (int c = 0; c < 50 && !hit; c++) begin
            step;
            hit = mem_rd_ready;
        end
        check64("rst_mid_reached_rd_data", 64'(hit), 64'd1);
        repeat (3) step;
        fin_before = fin_cnt;
        reset = 1'b0;
        #1;
        any_out = finish | mem_req_valid | mem_req_opcode | (|mem_req_len) | (|mem_req_addr)
                | mem_wr_valid | (|mem_wr_bits) | mem_rd_ready | (|cycles);
        check64("rst_mid_outputs_zero", 64'(any_out), 64'd0);
        repeat (2) step;
        reset = 1'b1;
        step;
        check64("rst_mid_no_finish", 64'(fin_cnt), 64'(fin_before));
        run_vec(v6, "relaunch");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
